// File: rtl/vga_draw_rect.sv
// ---------------------------------------------------------------------------
// vga_draw_rect
//
// Rectangle filler that sits between the control/game logic and vga_adapter.
// One command fills a W x H rectangle at (x0, y0) with a single colour, one
// pixel per clock, in row-major order. A clear-screen command paints the
// whole visible area black. Rectangles are clipped to the screen.
//
// Handshake (start/busy/done):
//   start and clear_scr are sampled only while busy is low (FSM in IDLE);
//   clear_scr has priority over start. The command operands are latched on
//   the accepting edge and may change freely afterwards. busy is high from
//   the cycle after acceptance until (and including) the done cycle; done is
//   a single-cycle pulse following the last pixel, or following acceptance
//   when the clipped rectangle is empty. Requests presented while busy is
//   high are dropped, not queued.
//
// Ports:
//   clock        system clock
//   resetn       asynchronous active-low reset
//   start        draw request
//   clear_scr    clear-screen request (beats start)
//   x0, y0       rectangle top-left corner
//   w, h         rectangle size in pixels (0 means nothing to draw)
//   colour_in    fill colour
//   X, Y         current pixel coordinate (to vga_adapter x/y)
//   colour_out   current pixel colour (to vga_adapter colour)
//   plot_enable  pixel write strobe (to vga_adapter plot)
//   busy         command in progress
//   done         one-cycle completion pulse
//   dbg_state    current FSM state (0 IDLE, 1 DRAW, 2 DONE)
// ---------------------------------------------------------------------------
module vga_draw_rect #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic                clear_scr,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      w,
    input  logic [Y_W-1:0]      h,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic [X_W-1:0]      X,
    output logic [Y_W-1:0]      Y,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot_enable,
    output logic                busy,
    output logic                done,
    output logic [1:0]          dbg_state
);

    // Screen limits expressed in the one-bit-wider end-coordinate width so
    // that x0+w / y0+h can be compared without wrapping.
    localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);
    localparam logic [X_W:0] X_ONE = (X_W+1)'(1);
    localparam logic [Y_W:0] Y_ONE = (Y_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Latched command: left column (row wrap target) and exclusive ends.
    logic [X_W-1:0]      x_org, x_org_nxt;
    logic [X_W:0]        x_end, x_end_nxt;
    logic [Y_W:0]        y_end, y_end_nxt;

    logic [X_W-1:0]      x_nxt;
    logic [Y_W-1:0]      y_nxt;
    logic [COLOUR_W-1:0] colour_nxt;
    logic                plot_nxt;
    logic                busy_nxt;
    logic                done_nxt;

    // Clipped end coordinates and emptiness of the incoming command.
    logic [X_W:0]        x_sum, x_clip;
    logic [Y_W:0]        y_sum, y_clip;
    logic                cmd_empty;

    // Scan position tests on the pixel currently being presented.
    logic                last_col, last_row;

    assign dbg_state = state;

    always_comb begin
        x_sum     = {1'b0, x0} + {1'b0, w};
        y_sum     = {1'b0, y0} + {1'b0, h};
        x_clip    = (x_sum > X_LIM) ? X_LIM : x_sum;
        y_clip    = (y_sum > Y_LIM) ? Y_LIM : y_sum;
        // An origin off-screen or a zero dimension yields no pixels at all.
        cmd_empty = (w == '0) || (h == '0) ||
                    ({1'b0, x0} >= X_LIM) || ({1'b0, y0} >= Y_LIM);
        last_col  = ({1'b0, X} == (x_end - X_ONE));
        last_row  = ({1'b0, Y} == (y_end - Y_ONE));
    end

    // Next-state and next-output logic. Every output is a register, so this
    // block computes the values that appear on the ports after the edge.
    always_comb begin
        state_nxt  = state;
        x_org_nxt  = x_org;
        x_end_nxt  = x_end;
        y_end_nxt  = y_end;
        x_nxt      = X;
        y_nxt      = Y;
        colour_nxt = colour_out;
        plot_nxt   = 1'b0;
        busy_nxt   = busy;
        done_nxt   = 1'b0;

        case (state)
            S_IDLE: begin
                busy_nxt = 1'b0;
                if (clear_scr) begin
                    x_org_nxt  = '0;
                    x_end_nxt  = X_LIM;
                    y_end_nxt  = Y_LIM;
                    x_nxt      = '0;
                    y_nxt      = '0;
                    colour_nxt = '0;
                    plot_nxt   = 1'b1;
                    busy_nxt   = 1'b1;
                    state_nxt  = S_DRAW;
                end else if (start) begin
                    x_org_nxt = x0;
                    x_end_nxt = x_clip;
                    y_end_nxt = y_clip;
                    busy_nxt  = 1'b1;
                    if (cmd_empty) begin
                        // Nothing to plot: X/Y/colour keep their old values.
                        done_nxt  = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        x_nxt      = x0;
                        y_nxt      = y0;
                        colour_nxt = colour_in;
                        plot_nxt   = 1'b1;
                        state_nxt  = S_DRAW;
                    end
                end
            end

            S_DRAW: begin
                busy_nxt = 1'b1;
                if (last_col && last_row) begin
                    // Pixel just presented was the bottom-right corner.
                    done_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end else if (last_col) begin
                    x_nxt    = x_org;
                    y_nxt    = Y + 1'b1;
                    plot_nxt = 1'b1;
                end else begin
                    x_nxt    = X + 1'b1;
                    plot_nxt = 1'b1;
                end
            end

            S_DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end

            default: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            x_org       <= '0;
            x_end       <= '0;
            y_end       <= '0;
            X           <= '0;
            Y           <= '0;
            colour_out  <= '0;
            plot_enable <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            x_org       <= x_org_nxt;
            x_end       <= x_end_nxt;
            y_end       <= y_end_nxt;
            X           <= x_nxt;
            Y           <= y_nxt;
            colour_out  <= colour_nxt;
            plot_enable <= plot_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

endmodule
